// File: rtl/spi_cfg_master_pkg.sv
// Shared definitions for the SPI configuration master and its slave:
// FSM state encoding, register-select bytes and frame geometry.
package spi_cfg_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        GAP,
        FL_HI,
        FL_LO
    } spi_state_t;

    localparam logic [7:0] REG_BACKGROUND  = 8'h00;
    localparam logic [7:0] REG_SOLID_COLOR = 8'h01;
    localparam logic [7:0] REG_AUDIO_EN    = 8'h02;

    // Divider width covers twice the largest half-period (HOLD spans a full SCLK period).
    localparam int DIV_W = 9;

    // Index of the last of the 16 SCLK rising edges in a frame.
    localparam logic [3:0] LAST_BIT = 4'd15;

    function automatic logic [15:0] frame_word(input logic [7:0] addr, input logic [7:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/spi_cfg_master_clk_div.sv
// Load/terminal-count down counter that times every non-idle FSM state.
module spi_clk_div
    import spi_cfg_master_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tc
);

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_ONE;
        end
    end

    assign tc = (cnt_reg == '0);

endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 write-only configuration master: 16-bit {addr,data} frames
// with a slave-present AND of MISO, plus a single-pulse slave-clear flush.
module spi_cfg_master
    import spi_cfg_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       cmd_flush,
    output logic       cmd_ready,
    output logic       done,
    output logic       ack,
    output logic       SCLK,
    output logic       SSEL,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(CLK_DIV - 1);
    // HOLD stretches over a full SCLK period so the frame spans 17 SCLK periods plus the gap.
    localparam logic [DIV_W-1:0] HOLD_LOAD = DIV_W'(2 * CLK_DIV - 1);

    spi_state_t       state_reg, state_next;
    logic [15:0]      shift_reg, shift_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic             sclk_reg, sclk_next;
    logic             ssel_reg, ssel_next;
    logic             mosi_reg, mosi_next;
    logic             acc_reg, acc_next;
    logic             ack_reg, ack_next;
    logic             done_reg, done_next;
    logic             flush_reg, flush_next;
    logic             div_load, div_tc;
    logic [DIV_W-1:0] div_val;

    spi_clk_div u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .load_val (div_val),
        .tc       (div_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
            ssel_reg    <= 1'b1;
            mosi_reg    <= 1'b0;
            acc_reg     <= 1'b0;
            ack_reg     <= 1'b0;
            done_reg    <= 1'b0;
            flush_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            sclk_reg    <= sclk_next;
            ssel_reg    <= ssel_next;
            mosi_reg    <= mosi_next;
            acc_reg     <= acc_next;
            ack_reg     <= ack_next;
            done_reg    <= done_next;
            flush_reg   <= flush_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        sclk_next    = sclk_reg;
        ssel_next    = ssel_reg;
        mosi_next    = mosi_reg;
        acc_next     = acc_reg;
        ack_next     = ack_reg;
        done_next    = 1'b0;
        flush_next   = flush_reg;

        unique case (state_reg)
            IDLE: begin
                if (cmd_flush) begin
                    state_next = FL_HI;
                    flush_next = 1'b1;
                    sclk_next  = 1'b1;
                    ssel_next  = 1'b1;
                end else if (cmd_valid) begin
                    state_next   = SETUP;
                    flush_next   = 1'b0;
                    shift_next   = frame_word(cmd_addr, cmd_data);
                    mosi_next    = cmd_addr[7];
                    ssel_next    = 1'b0;
                    sclk_next    = 1'b0;
                    bit_cnt_next = '0;
                    acc_next     = 1'b1;
                end
            end
            SETUP, SCK_LO: begin
                if (div_tc) begin
                    state_next = SCK_HI;
                    sclk_next  = 1'b1;
                    acc_next   = acc_reg & MISO;
                end
            end
            SCK_HI: begin
                if (div_tc) begin
                    sclk_next = 1'b0;
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = HOLD;
                    end else begin
                        state_next   = SCK_LO;
                        shift_next   = {shift_reg[14:0], 1'b0};
                        mosi_next    = shift_reg[14];
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (div_tc) begin
                    state_next = GAP;
                    ssel_next  = 1'b1;
                    mosi_next  = 1'b0;
                end
            end
            GAP: begin
                if (div_tc) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    // A flush leaves the slave-present flag of the last frame intact.
                    if (!flush_reg) begin
                        ack_next = acc_reg;
                    end
                end
            end
            FL_HI: begin
                if (div_tc) begin
                    state_next = FL_LO;
                    sclk_next  = 1'b0;
                end
            end
            FL_LO: begin
                if (div_tc) begin
                    state_next = GAP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        div_load = (state_next != state_reg);
        div_val  = (state_next == HOLD) ? HOLD_LOAD : HALF_LOAD;
    end

    assign cmd_ready = (state_reg == IDLE);
    assign done      = done_reg;
    assign ack       = ack_reg;
    assign SCLK      = sclk_reg;
    assign SSEL      = ssel_reg;
    assign MOSI      = mosi_reg;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench: table of write frames on a CLK_DIV=2 master, plus flush,
// mid-frame reset, back-to-back and CLK_DIV=1 sequences.
module tb_spi_cfg_master;
    import spi_cfg_master_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_flush = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_data = '0;
    logic       cmd_ready, done, ack, sclk, ssel, mosi, miso;
    logic       miso_tie = 1'b1, kill9 = 1'b0;

    logic       cmd_valid1 = 1'b0;
    logic       flush1 = 1'b0;
    logic       cmd_ready1, done1, ack1, sclk1, ssel1, mosi1;
    logic       miso1 = 1'b1;

    int checks = 0;
    int errors = 0;

    spi_cfg_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_flush(cmd_flush), .cmd_ready(cmd_ready),
        .done(done), .ack(ack), .SCLK(sclk), .SSEL(ssel), .MOSI(mosi), .MISO(miso)
    );

    spi_cfg_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_flush(flush1), .cmd_ready(cmd_ready1),
        .done(done1), .ack(ack1), .SCLK(sclk1), .SSEL(ssel1), .MOSI(mosi1), .MISO(miso1)
    );

    // Slave/bus monitor for the CLK_DIV=2 master, sampled on the falling clk edge.
    logic        mon_clr = 1'b1;
    int          edges = 0, fl_edges = 0, ssel_lows = 0, gap_cnt = 0, last_gap = 0;
    logic [15:0] rx = '0;
    logic        prev_sclk = 1'b0, prev_ssel = 1'b1;

    assign miso = miso_tie & ~(kill9 & (edges == 8));

    always @(negedge clk) begin
        if (mon_clr) begin
            edges <= 0; fl_edges <= 0; ssel_lows <= 0; gap_cnt <= 0; last_gap <= 0; rx <= '0;
        end else begin
            if (sclk && !prev_sclk) begin
                if (!ssel) begin
                    edges <= edges + 1;
                    rx    <= {rx[14:0], mosi};
                end else begin
                    fl_edges <= fl_edges + 1;
                end
            end
            if (!ssel && prev_ssel) begin
                ssel_lows <= ssel_lows + 1;
                last_gap  <= gap_cnt;
            end
            gap_cnt <= ssel ? gap_cnt + 1 : 0;
        end
        prev_sclk <= sclk;
        prev_ssel <= ssel;
    end

    // Monitor for the CLK_DIV=1 master: edge count, data and SCLK period.
    int          edges1 = 0, cyc1 = 0, last_rise1 = 0, per_err1 = 0;
    logic [15:0] rx1 = '0;
    logic        prev_sclk1 = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            edges1 <= 0; cyc1 <= 0; last_rise1 <= 0; per_err1 <= 0; rx1 <= '0;
        end else begin
            cyc1 <= cyc1 + 1;
            if (sclk1 && !prev_sclk1) begin
                edges1     <= edges1 + 1;
                rx1        <= {rx1[14:0], mosi1};
                last_rise1 <= cyc1;
                if (edges1 > 0 && (cyc1 - last_rise1) != 2) per_err1 <= per_err1 + 1;
            end
        end
        prev_sclk1 <= sclk1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    // Issue one command on the CLK_DIV=2 master and return accept-to-done latency.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] d, input logic v,
                             input logic f, output int lat);
        @(negedge clk);
        chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_addr = a; cmd_data = d; cmd_valid = v; cmd_flush = f;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_flush = 1'b0;
        cmd_addr = ~a; cmd_data = ~d;
        lat = 0;
        while (!done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        miso_tie;
        logic        kill9;
        logic [15:0] exp_word;
        logic        exp_ack;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat;
        int n;
        int dn;
        logic done_seen;

        vecs[0] = '{REG_SOLID_COLOR, 8'h2A, 1'b1, 1'b0, 16'h012A, 1'b1};
        vecs[1] = '{REG_SOLID_COLOR, 8'h2A, 1'b0, 1'b0, 16'h012A, 1'b0};
        vecs[2] = '{REG_SOLID_COLOR, 8'h2A, 1'b1, 1'b1, 16'h012A, 1'b0};
        vecs[3] = '{REG_AUDIO_EN,    8'h05, 1'b1, 1'b0, 16'h0205, 1'b1};
        vecs[4] = '{REG_BACKGROUND,  8'hC3, 1'b1, 1'b0, 16'h00C3, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_ssel", {31'd0, ssel}, 32'd1);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk) rst = 1'b0;

        // Table-driven write frames at CLK_DIV=2.
        for (int i = 0; i < 5; i++) begin
            clr_mon();
            miso_tie = vecs[i].miso_tie;
            kill9    = vecs[i].kill9;
            run_frame(vecs[i].addr, vecs[i].data, 1'b1, 1'b0, lat);
            chk("frame_latency", lat, 32'd70);
            chk("frame_edges", edges, 32'd16);
            chk("frame_word", {16'd0, rx}, {16'd0, vecs[i].exp_word});
            chk("frame_ack", {31'd0, ack}, {31'd0, vecs[i].exp_ack});
            chk("frame_idle_sclk", fl_edges, 32'd0);
            chk("frame_ssel_lows", ssel_lows, 32'd1);
            $display("vec %0d addr=%h data=%h rx=%h edges=%0d ack=%b lat=%0d",
                     i, vecs[i].addr, vecs[i].data, rx, edges, ack, lat);
        end
        kill9 = 1'b0;

        // Flush and write requested together: flush wins, ack untouched.
        clr_mon();
        miso_tie = 1'b0;
        run_frame(REG_SOLID_COLOR, 8'h2A, 1'b1, 1'b1, lat);
        chk("flush_latency", lat, 32'd6);
        chk("flush_pulses", fl_edges, 32'd1);
        chk("flush_no_write_edges", edges, 32'd0);
        chk("flush_ssel_never_low", ssel_lows, 32'd0);
        chk("flush_ack_kept", {31'd0, ack}, 32'd1);
        $display("flush lat=%0d pulses=%0d ssel_lows=%0d ack=%b", lat, fl_edges, ssel_lows, ack);

        // Reset after the 5th SCLK edge, then a clean frame.
        clr_mon();
        miso_tie = 1'b1;
        @(negedge clk);
        cmd_addr = REG_SOLID_COLOR; cmd_data = 8'h2A; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        n = 0;
        while (edges < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_edge5", edges, 32'd5);
        chk("abort_busy_ready", {31'd0, cmd_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("abort_ssel", {31'd0, ssel}, 32'd1);
        chk("abort_sclk", {31'd0, sclk}, 32'd0);
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            done_seen = done_seen | done;
        end
        @(negedge clk) rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            done_seen = done_seen | done;
        end
        chk("abort_no_done", {31'd0, done_seen}, 32'd0);
        chk("abort_no_more_edges", edges, 32'd5);
        chk("abort_ack_cleared", {31'd0, ack}, 32'd0);
        clr_mon();
        run_frame(REG_AUDIO_EN, 8'h05, 1'b1, 1'b0, lat);
        chk("restart_word", {16'd0, rx}, 32'h0205);
        chk("restart_edges", edges, 32'd16);
        chk("restart_latency", lat, 32'd70);
        chk("restart_ack", {31'd0, ack}, 32'd1);
        $display("abort+restart rx=%h edges=%0d lat=%0d ack=%b", rx, edges, lat, ack);

        // cmd_valid held high: two back-to-back frames.
        clr_mon();
        @(negedge clk);
        cmd_addr = REG_SOLID_COLOR; cmd_data = 8'h2A; cmd_valid = 1'b1;
        n = 0; dn = 0;
        while (dn < 2 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (done) dn++;
        end
        cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_done_count", dn, 32'd2);
        chk("b2b_frames", ssel_lows, 32'd2);
        chk("b2b_edges", edges, 32'd32);
        chk("b2b_gap_min", {31'd0, (last_gap >= 2)}, 32'd1);
        chk("b2b_gap_quiet", fl_edges, 32'd0);
        chk("b2b_word", {16'd0, rx}, 32'h012A);
        $display("b2b frames=%0d edges=%0d gap=%0d rx=%h", ssel_lows, edges, last_gap, rx);

        // CLK_DIV=1 boundary on the second instance.
        clr_mon();
        @(negedge clk);
        cmd_addr = REG_SOLID_COLOR; cmd_data = 8'h2A; cmd_valid1 = 1'b1;
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("div1_latency", lat, 32'd35);
        chk("div1_edges", edges1, 32'd16);
        chk("div1_word", {16'd0, rx1}, 32'h012A);
        chk("div1_period", per_err1, 32'd0);
        chk("div1_ack", {31'd0, ack1}, 32'd1);
        $display("div1 rx=%h edges=%0d lat=%0d period_errs=%0d ack=%b", rx1, edges1, lat, per_err1, ack1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
